// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite 1-to-N crossbar.
// Contents: response codes, one-hot read/write FSM state enums,
// and a helper that sizes slave-select fields.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [3:0] {
        R_IDLE = 4'b0001,
        R_ADDR = 4'b0010,
        R_DATA = 4'b0100,
        R_ERR  = 4'b1000
    } rd_state_t;

    typedef enum logic [3:0] {
        W_IDLE = 4'b0001,
        W_REQ  = 4'b0010,
        W_RESP = 4'b0100,
        W_ERR  = 4'b1000
    } wr_state_t;

    // A single-slave configuration still needs a 1-bit select field.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational address decoder for the AXI4-Lite crossbar.
// Ports:
//   i_addr  in  32    address to decode
//   o_hit   out 1     some slave window matched
//   o_sel   out SELW  index of the lowest-numbered matching slave (0 on miss)
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter int unsigned              NSLV     = 2,
    parameter int unsigned              SELW     = 1,
    parameter logic [NSLV-1:0][31:0]    SLV_BASE = '0,
    parameter logic [NSLV-1:0][31:0]    SLV_MASK = '0
) (
    input  logic [31:0]      i_addr,
    output logic             o_hit,
    output logic [SELW-1:0]  o_sel
);

    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        // Lowest index wins: later matches are ignored once a hit is found.
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!o_hit && ((i_addr & SLV_MASK[i]) == SLV_BASE[i])) begin
                o_hit = 1'b1;
                o_sel = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/axi4_lite_xbar_1ton.sv
// AXI4-Lite 1-master to NSLV-slave address router.
// Independent read and write FSMs, one outstanding transaction on each.
// Optional macro XBAR_DECERR_EN: address misses are answered locally with
// DECERR; without it misses are routed to slave NSLV-1.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mar*/mr*                          master read address / read data
//   maw*/mw*/mb*                      master write address / data / response
//   sar*/sr*                          per-slave read address / read data
//   saw*/sw*/sb*                      per-slave write address / data / response
// Slave index 0 occupies the least-significant slot of every packed array.
module axi4_lite_xbar_1ton
    import axi4_lite_pkg::*;
#(
    parameter int unsigned              NSLV     = 2,
    parameter logic [NSLV-1:0][31:0]    SLV_BASE = {32'h8000_0000, 32'h1000_0000},
    parameter logic [NSLV-1:0][31:0]    SLV_MASK = {32'hF000_0000, 32'hF000_0000}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 maraddr,
    input  logic                        marvalid,
    output logic                        marready,
    output logic [31:0]                 mrdata,
    output logic [1:0]                  mrresp,
    output logic                        mrvalid,
    input  logic                        mrready,
    input  logic [31:0]                 mawaddr,
    input  logic                        mawvalid,
    output logic                        mawready,
    input  logic [31:0]                 mwdata,
    input  logic [3:0]                  mwstrb,
    input  logic                        mwvalid,
    output logic                        mwready,
    output logic [1:0]                  mbresp,
    output logic                        mbvalid,
    input  logic                        mbready,
    output logic [NSLV-1:0][31:0]       saraddr,
    output logic [NSLV-1:0]             sarvalid,
    input  logic [NSLV-1:0]             sarready,
    input  logic [NSLV-1:0][31:0]       srdata,
    input  logic [NSLV-1:0][1:0]        srresp,
    input  logic [NSLV-1:0]             srvalid,
    output logic [NSLV-1:0]             srready,
    output logic [NSLV-1:0][31:0]       sawaddr,
    output logic [NSLV-1:0]             sawvalid,
    input  logic [NSLV-1:0]             sawready,
    output logic [NSLV-1:0][31:0]       swdata,
    output logic [NSLV-1:0][3:0]        swstrb,
    output logic [NSLV-1:0]             swvalid,
    input  logic [NSLV-1:0]             swready,
    input  logic [NSLV-1:0][1:0]        sbresp,
    input  logic [NSLV-1:0]             sbvalid,
    output logic [NSLV-1:0]             sbready
);

    localparam int unsigned SELW = sel_width(NSLV);

    rd_state_t          r_rd_state, w_rd_state_n;
    wr_state_t          r_wr_state, w_wr_state_n;
    logic [31:0]        r_raddr, r_waddr, r_wdata;
    logic [3:0]         r_wstrb;
    logic [SELW-1:0]    r_rsel, r_wsel;
    logic               r_aw_got, r_w_got, r_aw_sent, r_w_sent;
`ifdef XBAR_DECERR_EN
    logic               r_whit;
`endif

    logic               w_ar_hit, w_aw_hit;
    logic [SELW-1:0]    w_ar_sel, w_aw_sel, w_ar_route, w_aw_route;
    logic               w_aw_take, w_w_take, w_aw_have, w_w_have;
    logic               w_aw_hs, w_w_hs, w_wr_clear;

    axi4_lite_addr_decode #(.NSLV(NSLV), .SELW(SELW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
        u_ar_dec (.i_addr(maraddr), .o_hit(w_ar_hit), .o_sel(w_ar_sel));
    axi4_lite_addr_decode #(.NSLV(NSLV), .SELW(SELW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
        u_aw_dec (.i_addr(mawaddr), .o_hit(w_aw_hit), .o_sel(w_aw_sel));

`ifdef XBAR_DECERR_EN
    assign w_ar_route = w_ar_sel;
    assign w_aw_route = w_aw_sel;
`else
    // Misses fall through to the default slave.
    assign w_ar_route = w_ar_hit ? w_ar_sel : SELW'(NSLV-1);
    assign w_aw_route = w_aw_hit ? w_aw_sel : SELW'(NSLV-1);
`endif

    // Derived from state, not from mawready/mwready, to avoid a combinational loop.
    assign w_aw_take = (r_wr_state == W_IDLE) && !r_aw_got && mawvalid;
    assign w_w_take  = (r_wr_state == W_IDLE) && !r_w_got  && mwvalid;
    assign w_aw_have = r_aw_got | w_aw_take;
    assign w_w_have  = r_w_got  | w_w_take;
    assign w_aw_hs   = (r_wr_state == W_REQ) && !r_aw_sent && sawready[r_wsel];
    assign w_w_hs    = (r_wr_state == W_REQ) && !r_w_sent  && swready[r_wsel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
        end else begin
            r_rd_state <= w_rd_state_n;
            r_wr_state <= w_wr_state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr   <= '0;
            r_rsel    <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wsel    <= '0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_aw_sent <= 1'b0;
            r_w_sent  <= 1'b0;
`ifdef XBAR_DECERR_EN
            r_whit    <= 1'b0;
`endif
        end else begin
            if ((r_rd_state == R_IDLE) && marvalid) begin
                r_raddr <= maraddr;
                r_rsel  <= w_ar_route;
            end
            if (w_aw_take) begin
                r_aw_got <= 1'b1;
                r_waddr  <= mawaddr;
                r_wsel   <= w_aw_route;
`ifdef XBAR_DECERR_EN
                r_whit   <= w_aw_hit;
`endif
            end
            if (w_w_take) begin
                r_w_got <= 1'b1;
                r_wdata <= mwdata;
                r_wstrb <= mwstrb;
            end
            if (w_aw_hs) r_aw_sent <= 1'b1;
            if (w_w_hs)  r_w_sent  <= 1'b1;
            if (w_wr_clear) begin
                r_aw_got  <= 1'b0;
                r_w_got   <= 1'b0;
                r_aw_sent <= 1'b0;
                r_w_sent  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_state_n = r_rd_state;
        marready     = 1'b0;
        sarvalid     = '0;
        srready      = '0;
        mrvalid      = 1'b0;
        mrdata       = '0;
        mrresp       = RESP_OKAY;
        for (int unsigned i = 0; i < NSLV; i++) saraddr[i] = r_raddr;
        case (r_rd_state)
            R_IDLE: begin
                marready = 1'b1;
                if (marvalid) begin
`ifdef XBAR_DECERR_EN
                    w_rd_state_n = w_ar_hit ? R_ADDR : R_ERR;
`else
                    w_rd_state_n = R_ADDR;
`endif
                end
            end
            R_ADDR: begin
                sarvalid[r_rsel] = 1'b1;
                if (sarready[r_rsel]) w_rd_state_n = R_DATA;
            end
            R_DATA: begin
                mrvalid         = srvalid[r_rsel];
                mrdata          = srdata[r_rsel];
                mrresp          = srresp[r_rsel];
                srready[r_rsel] = mrready;
                if (srvalid[r_rsel] && mrready) w_rd_state_n = R_IDLE;
            end
`ifdef XBAR_DECERR_EN
            R_ERR: begin
                mrvalid = 1'b1;
                mrresp  = RESP_DECERR;
                if (mrready) w_rd_state_n = R_IDLE;
            end
`endif
            default: w_rd_state_n = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_state_n = r_wr_state;
        mawready     = 1'b0;
        mwready      = 1'b0;
        sawvalid     = '0;
        swvalid      = '0;
        sbready      = '0;
        mbvalid      = 1'b0;
        mbresp       = RESP_OKAY;
        w_wr_clear   = 1'b0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            sawaddr[i] = r_waddr;
            swdata[i]  = r_wdata;
            swstrb[i]  = r_wstrb;
        end
        case (r_wr_state)
            W_IDLE: begin
                mawready = !r_aw_got;
                mwready  = !r_w_got;
                if (w_aw_have && w_w_have) begin
`ifdef XBAR_DECERR_EN
                    w_wr_state_n = (r_aw_got ? r_whit : w_aw_hit) ? W_REQ : W_ERR;
`else
                    w_wr_state_n = W_REQ;
`endif
                end
            end
            W_REQ: begin
                sawvalid[r_wsel] = !r_aw_sent;
                swvalid[r_wsel]  = !r_w_sent;
                if ((r_aw_sent || w_aw_hs) && (r_w_sent || w_w_hs)) w_wr_state_n = W_RESP;
            end
            W_RESP: begin
                mbvalid         = sbvalid[r_wsel];
                mbresp          = sbresp[r_wsel];
                sbready[r_wsel] = mbready;
                if (sbvalid[r_wsel] && mbready) begin
                    w_wr_state_n = W_IDLE;
                    w_wr_clear   = 1'b1;
                end
            end
`ifdef XBAR_DECERR_EN
            W_ERR: begin
                mbvalid = 1'b1;
                mbresp  = RESP_DECERR;
                if (mbready) begin
                    w_wr_state_n = W_IDLE;
                    w_wr_clear   = 1'b1;
                end
            end
`endif
            default: begin
                w_wr_state_n = W_IDLE;
                w_wr_clear   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_xbar_1ton.sv
// Self-checking bench for axi4_lite_xbar_1ton (NSLV=2: slave0 at 0x1xxx_xxxx,
// slave1 at 0x8xxx_xxxx). A transaction-level model tracks the one
// outstanding read and write and predicts every output on each negedge;
// directed literal checks pin the scenarios. Honors XBAR_DECERR_EN.
module tb_axi4_lite_xbar_1ton;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       maraddr, mrdata, mawaddr, mwdata;
    logic              marvalid, marready, mrvalid, mrready;
    logic [1:0]        mrresp, mbresp;
    logic              mawvalid, mawready, mwvalid, mwready, mbvalid, mbready;
    logic [3:0]        mwstrb;
    logic [1:0][31:0]  saraddr, srdata, sawaddr, swdata;
    logic [1:0]        sarvalid, sarready, srvalid, srready;
    logic [1:0][1:0]   srresp, sbresp;
    logic [1:0]        sawvalid, sawready, swvalid, swready, sbvalid, sbready;
    logic [1:0][3:0]   swstrb;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    axi4_lite_xbar_1ton #(.NSLV(2)) dut (
        .clk(clk), .rst(rst),
        .maraddr(maraddr), .marvalid(marvalid), .marready(marready),
        .mrdata(mrdata), .mrresp(mrresp), .mrvalid(mrvalid), .mrready(mrready),
        .mawaddr(mawaddr), .mawvalid(mawvalid), .mawready(mawready),
        .mwdata(mwdata), .mwstrb(mwstrb), .mwvalid(mwvalid), .mwready(mwready),
        .mbresp(mbresp), .mbvalid(mbvalid), .mbready(mbready),
        .saraddr(saraddr), .sarvalid(sarvalid), .sarready(sarready),
        .srdata(srdata), .srresp(srresp), .srvalid(srvalid), .srready(srready),
        .sawaddr(sawaddr), .sawvalid(sawvalid), .sawready(sawready),
        .swdata(swdata), .swstrb(swstrb), .swvalid(swvalid), .swready(swready),
        .sbresp(sbresp), .sbvalid(sbvalid), .sbready(sbready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Target slave for an address; -1 means answered locally with DECERR.
    function automatic int dec(input logic [31:0] a);
        if ((a & 32'hF000_0000) == 32'h1000_0000) return 0;
        if ((a & 32'hF000_0000) == 32'h8000_0000) return 1;
`ifdef XBAR_DECERR_EN
        return -1;
`else
        return 1;
`endif
    endfunction

    // Transaction-level model state.
    bit          rb, rs;          // read outstanding, read address delivered
    int          rt;
    logic [31:0] ra;
    bit          wah, wwh, was, wws;
    int          wt;
    logic [31:0] wa, wd;
    logic [3:0]  wsb;

    always @(negedge clk) begin
        bit wbusy, ev;
        if (model_on) begin
            chk("m_marready", marready, !rb);
            for (int s = 0; s < 2; s++) begin
                chk("m_sarvalid", sarvalid[s], rb && !rs && rt == s);
                chk("m_srready", srready[s], rb && rs && rt == s && mrready);
            end
            if (rb && !rs) chk("m_saraddr", saraddr[rt], ra);
            ev = (rb && rs) ? ((rt < 0) ? 1'b1 : srvalid[rt]) : 1'b0;
            chk("m_mrvalid", mrvalid, ev);
            if (ev) begin
                chk("m_mrdata", mrdata, (rt < 0) ? 32'h0 : srdata[rt]);
                chk("m_mrresp", mrresp, (rt < 0) ? 2'b11 : srresp[rt]);
            end
            wbusy = wah && wwh;
            chk("m_mawready", mawready, !wah);
            chk("m_mwready", mwready, !wwh);
            for (int s = 0; s < 2; s++) begin
                chk("m_sawvalid", sawvalid[s], wbusy && wt == s && !was);
                chk("m_swvalid", swvalid[s], wbusy && wt == s && !wws);
                chk("m_sbready", sbready[s], wbusy && was && wws && wt == s && mbready);
            end
            if (wbusy && !was) chk("m_sawaddr", sawaddr[wt], wa);
            if (wbusy && !wws) begin
                chk("m_swdata", swdata[wt], wd);
                chk("m_swstrb", swstrb[wt], wsb);
            end
            ev = (wbusy && was && wws) ? ((wt < 0) ? 1'b1 : sbvalid[wt]) : 1'b0;
            chk("m_mbvalid", mbvalid, ev);
            if (ev) chk("m_mbresp", mbresp, (wt < 0) ? 2'b11 : sbresp[wt]);

            // Advance the model over the coming edge.
            if (rst) begin
                rb = 0; rs = 0; wah = 0; wwh = 0; was = 0; wws = 0;
            end else begin
                if (!rb) begin
                    if (marvalid) begin
                        rb = 1; rt = dec(maraddr); ra = maraddr; rs = (rt < 0);
                    end
                end else if (!rs) begin
                    if (sarready[rt]) rs = 1;
                end else if (((rt < 0) || srvalid[rt]) && mrready) begin
                    rb = 0;
                end
                if (!wbusy) begin
                    if (!wah && mawvalid) begin wah = 1; wa = mawaddr; wt = dec(mawaddr); end
                    if (!wwh && mwvalid) begin wwh = 1; wd = mwdata; wsb = mwstrb; end
                    if (wah && wwh && wt < 0) begin was = 1; wws = 1; end
                end else if (!(was && wws)) begin
                    if (!was && sawready[wt]) was = 1;
                    if (!wws && swready[wt]) wws = 1;
                end else if (((wt < 0) || sbvalid[wt]) && mbready) begin
                    wah = 0; wwh = 0; was = 0; wws = 0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        maraddr = '0; marvalid = 0; mrready = 0;
        mawaddr = '0; mawvalid = 0; mwdata = '0; mwstrb = '0; mwvalid = 0; mbready = 0;
        sarready = '0; srdata = '0; srresp = '0; srvalid = '0;
        sawready = '0; swready = '0; sbresp = '0; sbvalid = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_marready", marready, 1'b1);
        chk("rst_mawready", mawready, 1'b1);
        chk("rst_mwready", mwready, 1'b1);
        chk("rst_valids", {sarvalid, sawvalid, swvalid, mrvalid, mbvalid}, 8'h00);
        chk("rst_readies", {srready, sbready}, 4'h0);
        model_on = 1'b1;
        tick();
        rst = 1'b0;

        // 1: read slave0
        maraddr = 32'h1000_0004; marvalid = 1; mrready = 1;
        tick(); marvalid = 0;
        @(negedge clk);
        chk("t1_sarvalid", sarvalid, 2'b01);
        chk("t1_saraddr", saraddr[0], 32'h1000_0004);
        tick(); sarready[0] = 1;
        tick(); sarready[0] = 0; srdata[0] = 32'hDEAD_BEEF; srresp[0] = 2'b00; srvalid[0] = 1;
        @(negedge clk);
        chk("t1_mrvalid", mrvalid, 1'b1);
        chk("t1_mrdata", mrdata, 32'hDEAD_BEEF);
        tick(); srvalid[0] = 0;
        @(negedge clk);
        chk("t1_idle", {marready, mrvalid}, 2'b10);

        // 2: write, W two cycles before AW, to slave1
        tick();
        mwdata = 32'h1234_5678; mwstrb = 4'hF; mwvalid = 1; mbready = 1;
        tick(); mwvalid = 0;
        tick(); mawaddr = 32'h8000_0010; mawvalid = 1;
        tick(); mawvalid = 0;
        @(negedge clk);
        chk("t2_sawvalid", sawvalid, 2'b10);
        chk("t2_swvalid", swvalid, 2'b10);
        chk("t2_sawaddr", sawaddr[1], 32'h8000_0010);
        chk("t2_swdata", swdata[1], 32'h1234_5678);
        tick(); sawready[1] = 1; swready[1] = 1;
        tick(); sawready[1] = 0; swready[1] = 0; sbvalid[1] = 1; sbresp[1] = 2'b00;
        @(negedge clk);
        chk("t2_mbvalid", mbvalid, 1'b1);
        chk("t2_mbresp", mbresp, 2'b00);
        tick(); sbvalid[1] = 0;
        @(negedge clk);
        chk("t2_idle", {mawready, mwready, mbvalid}, 3'b110);

        // 3: unmapped read
        tick();
        maraddr = 32'h0000_0000; marvalid = 1;
        tick(); marvalid = 0;
        @(negedge clk);
`ifdef XBAR_DECERR_EN
        chk("t3_mrresp", mrresp, 2'b11);
        chk("t3_mrdata", mrdata, 32'h0);
        chk("t3_sarvalid", sarvalid, 2'b00);
        tick();
`else
        chk("t3_sarvalid", sarvalid, 2'b10);
        tick(); sarready[1] = 1;
        tick(); sarready[1] = 0; srdata[1] = 32'h55AA_33CC; srvalid[1] = 1;
        @(negedge clk);
        chk("t3_mrdata", mrdata, 32'h55AA_33CC);
        tick(); srvalid[1] = 0;
`endif

        // 4: concurrent read slave0 / write slave1, read stalled by master
        maraddr = 32'h1000_0008; marvalid = 1; mrready = 0;
        mawaddr = 32'h8000_0020; mawvalid = 1;
        mwdata = 32'hCAFE_F00D; mwstrb = 4'h3; mwvalid = 1; mbready = 1;
        tick(); marvalid = 0; mawvalid = 0; mwvalid = 0;
        @(negedge clk);
        chk("t4_sarvalid", sarvalid, 2'b01);
        chk("t4_sawvalid", sawvalid, 2'b10);
        tick(); sarready[0] = 1; sawready[1] = 1; swready[1] = 1;
        tick(); sarready[0] = 0; sawready[1] = 0; swready[1] = 0;
        srvalid[0] = 1; srdata[0] = 32'hA5A5_0001; srresp[0] = 2'b00;
        sbvalid[1] = 1; sbresp[1] = 2'b10;
        @(negedge clk);
        chk("t4_mbresp", mbresp, 2'b10);
        chk("t4_mrresp", mrresp, 2'b00);
        chk("t4_srready", srready, 2'b00);
        tick(); sbvalid[1] = 0;
        @(negedge clk);
        chk("t4_wdone", {mbvalid, mrvalid}, 2'b01);
        tick();
        @(negedge clk);
        chk("t4_stall", mrvalid, 1'b1);
        tick(); mrready = 1;
        @(negedge clk);
        chk("t4_mrdata", mrdata, 32'hA5A5_0001);
        tick(); srvalid[0] = 0;
        @(negedge clk);
        chk("t4_idle", marready, 1'b1);

        // 5: slave1 holds sarready low for 5 cycles
        tick();
        maraddr = 32'h8000_0040; marvalid = 1;
        tick(); marvalid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_sarvalid", sarvalid, 2'b10);
            chk("t5_saraddr", saraddr[1], 32'h8000_0040);
            chk("t5_marready", marready, 1'b0);
            tick();
        end
        sarready[1] = 1;
        tick(); sarready[1] = 0; srvalid[1] = 1; srdata[1] = 32'h0BAD_F00D; srresp[1] = 2'b01;
        @(negedge clk);
        chk("t5_mrresp", mrresp, 2'b01);
        tick(); srvalid[1] = 0;

        // 6: reset while waiting for read data, then a fresh read
        maraddr = 32'h1000_000C; marvalid = 1;
        tick(); marvalid = 0; sarready[0] = 1;
        tick(); sarready[0] = 0;
        @(negedge clk);
        chk("t6_busy", marready, 1'b0);
        tick(); rst = 1;
        tick(); rst = 0;
        @(negedge clk);
        chk("t6_valids", {sarvalid, sawvalid, swvalid, mrvalid, mbvalid}, 8'h00);
        chk("t6_marready", marready, 1'b1);
        maraddr = 32'h1000_0010;
        tick(); marvalid = 1;
        tick(); marvalid = 0; sarready[0] = 1;
        tick(); sarready[0] = 0; srvalid[0] = 1; srdata[0] = 32'h1357_9BDF; srresp[0] = 2'b00;
        @(negedge clk);
        chk("t6_mrdata", mrdata, 32'h1357_9BDF);
        tick(); srvalid[0] = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
